cmp_hysteresis_monitor: RTL and testbench
=========================================

Name: cmp_hysteresis_monitor

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes the comparator's 3-bit one-hot result code each valid cycle; A is the measured value and B the threshold.
- Debounces the result with a hysteresis FSM and produces a registered alarm, one-cycle rise/fall pulses, a saturating rise-event counter, and an illegal-code flag.

Parameters:
- DEBOUNCE, 3, consecutive qualifying samples needed to change alarm state; legal range 1..15.
- CNT_W, 8, width of the rise-event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cm_valid  input  1  cm carries a new comparator sample this cycle.
- cm  input  3  comparator code: bit0 = A<B, bit1 = A=B, bit2 = A>B; exactly one bit set when legal.
- alarm  output  1  debounced "A above threshold" state.
- rise_pulse  output  1  one-cycle pulse when alarm goes 0->1.
- fall_pulse  output  1  one-cycle pulse when alarm goes 1->0.
- event_count  output  CNT_W  number of rise events; saturates at all-ones.
- code_err  output  1  one-cycle pulse: a sample with a non-one-hot cm was received.
- err_sticky  output  1  set by any code_err; cleared only by rst.
- state  output  2  FSM state for debug: 0 LOW, 1 ARMING, 2 HIGH, 3 DISARMING.

Behaviour:
- Reset (async, immediate): state=LOW, streak=0; alarm, rise_pulse, fall_pulse, code_err, err_sticky = 0; event_count = 0.
- All outputs are registered. A sample on cycle n affects outputs after edge n+1. There is no combinational path from cm to any output.
- Sample qualification:
  - Only cycles with cm_valid=1 are samples.
  - cm_valid=0 freezes state, streak and counter, and the pulses drop to 0.
  - Illegal cm (000, 011, 101, 110, 111) with cm_valid=1: code_err=1 for one cycle, err_sticky=1. The sample is otherwise discarded: no state or streak change.
- Streak counter: 4 bits, internal.
- LOW (alarm=0):
  - GT: if DEBOUNCE=1, go to HIGH with a rise event; else go to ARMING, streak=1.
  - EQ or LT: stay in LOW.
- ARMING (alarm=0):
  - GT: streak+1; when the new streak equals DEBOUNCE, go to HIGH with a rise event and streak=0.
  - EQ: hold state and streak (the equality band neither advances nor resets the streak).
  - LT: go to LOW, streak=0.
- HIGH (alarm=1):
  - LT: if DEBOUNCE=1, go to LOW with a fall event; else go to DISARMING, streak=1.
  - EQ or GT: stay in HIGH.
- DISARMING (alarm=1):
  - LT: streak+1; when the new streak equals DEBOUNCE, go to LOW with a fall event and streak=0.
  - EQ: hold state and streak.
  - GT: go to HIGH, streak=0.
- Rise event:
  - alarm <= 1 and rise_pulse <= 1 for exactly one cycle.
  - event_count <= event_count+1, unless the counter is all-ones, in which case it holds.
- Fall event: alarm <= 0 and fall_pulse <= 1 for exactly one cycle; event_count unchanged.
- rise_pulse and fall_pulse are never high together. Each pulse deasserts on the next edge regardless of cm_valid.
- Back-to-back samples are accepted every cycle; there is no backpressure and no ready signal.
- Reset asserted mid-streak: everything returns to reset values immediately. After reset, counting restarts from LOW with no memory of the prior streak.
- DEBOUNCE outside 1..15 is unsupported. The implementation flags it with an elaboration-time check.

Test Plan:
- Reset, then 3 valid GT samples (cm=100) on consecutive cycles, DEBOUNCE=3 -> alarm=1 and rise_pulse=1 exactly on the cycle after the 3rd sample; event_count=1; state=2.
- From HIGH: LT, LT, GT, LT, LT, LT -> GT aborts to HIGH; alarm falls with fall_pulse only after the final 3 LTs; alarm stays 1 throughout the aborted attempt.
- From LOW: GT, EQ (cm=010), EQ, GT, GT with cm_valid gaps between samples -> EQ and gap cycles hold streak=1; alarm rises after the 3rd GT; event_count increments once.
- Illegal codes 000 and 110 with cm_valid=1, mid-ARMING at streak=2 -> code_err pulses once per bad sample; err_sticky=1; state and streak unchanged; the next GT completes the rise.
- CNT_W=2: drive 5 full rise/fall cycles -> event_count reads 1, 2, 3, 3, 3 (saturates).
- Assert rst asynchronously between edges while in DISARMING at streak=2 -> alarm=0, state=0, err_sticky=0 immediately, before the next edge. DEBOUNCE=1 build: a single GT sample rises and a single LT sample falls.

Source files
------------

// File: rtl/cmp_hysteresis_monitor.sv
// Debounces a one-hot magnitude-comparator result (A vs threshold B) with a
// hysteresis FSM; drives a registered alarm, edge pulses, rise counter and code-error flags.
module cmp_hysteresis_monitor #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cm_valid,
  input  logic [2:0]       cm,
  output logic             alarm,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_count,
  output logic             code_err,
  output logic             err_sticky,
  output logic [1:0]       state
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] DB = STREAK_W'(DEBOUNCE);

  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("cmp_hysteresis_monitor: DEBOUNCE must be in 1..15");
  end

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    ARMING    = 2'd1,
    HIGH      = 2'd2,
    DISARMING = 2'd3
  } fsm_t;

  fsm_t                fsm;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_inc;
  logic                legal;
  logic                gt;
  logic                lt;
  logic                cnt_full;

  assign state      = fsm;
  assign streak_inc = streak + STREAK_W'(1);
  assign gt         = (cm == 3'b100);
  assign lt         = (cm == 3'b001);
  assign legal      = (cm == 3'b001) || (cm == 3'b010) || (cm == 3'b100);
  assign cnt_full   = (event_count == {CNT_W{1'b1}});

  // Hysteresis FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= LOW;
      streak      <= '0;
      alarm       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      event_count <= '0;
      code_err    <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      code_err   <= 1'b0;
      if (cm_valid) begin
        if (!legal) begin
          code_err   <= 1'b1;
          err_sticky <= 1'b1;
        end else begin
          case (fsm)
            LOW: begin
              if (gt) begin
                if (DB == STREAK_W'(1)) begin
                  fsm        <= HIGH;
                  streak     <= '0;
                  alarm      <= 1'b1;
                  rise_pulse <= 1'b1;
                  if (!cnt_full) event_count <= event_count + CNT_W'(1);
                end else begin
                  fsm    <= ARMING;
                  streak <= STREAK_W'(1);
                end
              end
            end
            ARMING: begin
              if (gt) begin
                if (streak_inc == DB) begin
                  fsm        <= HIGH;
                  streak     <= '0;
                  alarm      <= 1'b1;
                  rise_pulse <= 1'b1;
                  if (!cnt_full) event_count <= event_count + CNT_W'(1);
                end else begin
                  streak <= streak_inc;
                end
              end else if (lt) begin
                fsm    <= LOW;
                streak <= '0;
              end
            end
            HIGH: begin
              if (lt) begin
                if (DB == STREAK_W'(1)) begin
                  fsm        <= LOW;
                  streak     <= '0;
                  alarm      <= 1'b0;
                  fall_pulse <= 1'b1;
                end else begin
                  fsm    <= DISARMING;
                  streak <= STREAK_W'(1);
                end
              end
            end
            DISARMING: begin
              if (lt) begin
                if (streak_inc == DB) begin
                  fsm        <= LOW;
                  streak     <= '0;
                  alarm      <= 1'b0;
                  fall_pulse <= 1'b1;
                end else begin
                  streak <= streak_inc;
                end
              end else if (gt) begin
                fsm    <= HIGH;
                streak <= '0;
              end
            end
            default: begin
              fsm    <= LOW;
              streak <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_hysteresis_monitor.sv
// Directed bench: DEBOUNCE=3/CNT_W=8, DEBOUNCE=3/CNT_W=2 and DEBOUNCE=1 instances share one stimulus stream.
module tb_cmp_hysteresis_monitor;

  localparam logic [2:0] LT = 3'b001;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       cm_valid;
  logic [2:0] cm;

  logic       a_alarm, a_rise, a_fall, a_err, a_sticky;
  logic [7:0] a_cnt;
  logic [1:0] a_state;
  logic       b_alarm, b_rise, b_fall, b_err, b_sticky;
  logic [1:0] b_cnt;
  logic [1:0] b_state;
  logic       c_alarm, c_rise, c_fall, c_err, c_sticky;
  logic [7:0] c_cnt;
  logic [1:0] c_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_hysteresis_monitor #(.DEBOUNCE(3), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm(cm),
    .alarm(a_alarm), .rise_pulse(a_rise), .fall_pulse(a_fall),
    .event_count(a_cnt), .code_err(a_err), .err_sticky(a_sticky), .state(a_state));

  cmp_hysteresis_monitor #(.DEBOUNCE(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm(cm),
    .alarm(b_alarm), .rise_pulse(b_rise), .fall_pulse(b_fall),
    .event_count(b_cnt), .code_err(b_err), .err_sticky(b_sticky), .state(b_state));

  cmp_hysteresis_monitor #(.DEBOUNCE(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm(cm),
    .alarm(c_alarm), .rise_pulse(c_rise), .fall_pulse(c_fall),
    .event_count(c_cnt), .code_err(c_err), .err_sticky(c_sticky), .state(c_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then sample 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [2:0] c);
    cm_valid = v;
    cm       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic al, input logic ri, input logic fa,
                       input logic [7:0] cnt, input logic [1:0] st);
    chk({tag, ".alarm"}, 32'(a_alarm), 32'(al));
    chk({tag, ".rise"},  32'(a_rise),  32'(ri));
    chk({tag, ".fall"},  32'(a_fall),  32'(fa));
    chk({tag, ".cnt"},   32'(a_cnt),   32'(cnt));
    chk({tag, ".state"}, 32'(a_state), 32'(st));
  endtask

  initial begin
    rst      = 1'b1;
    cm_valid = 1'b0;
    cm       = 3'b000;
    #12;
    chk_a("reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    chk("reset.err",    32'(a_err),    32'd0);
    chk("reset.sticky", 32'(a_sticky), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three consecutive GT samples rise the alarm on the cycle after the third.
    step(1'b1, GT); chk_a("t1.gt1", 1'b0, 1'b0, 1'b0, 8'd0, 2'd1);
    step(1'b1, GT); chk_a("t1.gt2", 1'b0, 1'b0, 1'b0, 8'd0, 2'd1);
    step(1'b1, GT); chk_a("t1.gt3", 1'b1, 1'b1, 1'b0, 8'd1, 2'd2);
    chk("t1.b_cnt", 32'(b_cnt), 32'd1);
    step(1'b0, GT); chk_a("t1.idle", 1'b1, 1'b0, 1'b0, 8'd1, 2'd2);

    // Aborted disarm: alarm stays high until three uninterrupted LTs.
    step(1'b1, LT); chk_a("t2.lt1", 1'b1, 1'b0, 1'b0, 8'd1, 2'd3);
    step(1'b1, LT); chk_a("t2.lt2", 1'b1, 1'b0, 1'b0, 8'd1, 2'd3);
    step(1'b1, GT); chk_a("t2.gt",  1'b1, 1'b0, 1'b0, 8'd1, 2'd2);
    step(1'b1, LT); chk_a("t2.lt3", 1'b1, 1'b0, 1'b0, 8'd1, 2'd3);
    step(1'b1, LT); chk_a("t2.lt4", 1'b1, 1'b0, 1'b0, 8'd1, 2'd3);
    step(1'b1, LT); chk_a("t2.lt5", 1'b0, 1'b0, 1'b1, 8'd1, 2'd0);
    step(1'b0, LT); chk_a("t2.idle", 1'b0, 1'b0, 1'b0, 8'd1, 2'd0);

    // EQ samples and invalid gaps hold the streak.
    step(1'b1, GT); chk_a("t3.gt1", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    step(1'b0, LT); chk_a("t3.gap1", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    step(1'b1, EQ); chk_a("t3.eq1", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    step(1'b0, LT);
    step(1'b1, EQ); chk_a("t3.eq2", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    step(1'b0, GT);
    step(1'b1, GT); chk_a("t3.gt2", 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    step(1'b0, LT);
    step(1'b1, GT); chk_a("t3.gt3", 1'b1, 1'b1, 1'b0, 8'd2, 2'd2);
    chk("t3.b_cnt", 32'(b_cnt), 32'd2);
    step(1'b1, LT);
    step(1'b1, LT);
    step(1'b1, LT); chk_a("t3.fall", 1'b0, 1'b0, 1'b1, 8'd2, 2'd0);

    // Illegal codes mid-arming are flagged but leave the streak intact.
    step(1'b1, GT);
    step(1'b1, GT); chk_a("t4.arm2", 1'b0, 1'b0, 1'b0, 8'd2, 2'd1);
    step(1'b1, 3'b000);
    chk_a("t4.bad000", 1'b0, 1'b0, 1'b0, 8'd2, 2'd1);
    chk("t4.err000", 32'(a_err), 32'd1);
    chk("t4.sticky", 32'(a_sticky), 32'd1);
    step(1'b1, 3'b110);
    chk_a("t4.bad110", 1'b0, 1'b0, 1'b0, 8'd2, 2'd1);
    chk("t4.err110", 32'(a_err), 32'd1);
    step(1'b0, GT);
    chk("t4.err_drop", 32'(a_err), 32'd0);
    chk("t4.sticky_hold", 32'(a_sticky), 32'd1);
    step(1'b1, GT); chk_a("t4.rise", 1'b1, 1'b1, 1'b0, 8'd3, 2'd2);
    chk("t4.b_cnt", 32'(b_cnt), 32'd3);

    // Two more full cycles: the 2-bit counter saturates at 3.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, LT); step(1'b1, LT); step(1'b1, LT);
      chk("t5.fall", 32'(a_fall), 32'd1);
      step(1'b1, GT); step(1'b1, GT); step(1'b1, GT);
      chk("t5.a_cnt", 32'(a_cnt), 32'(4 + k));
      chk("t5.b_cnt", 32'(b_cnt), 32'd3);
      chk("t5.b_rise", 32'(b_rise), 32'd1);
    end

    // Asynchronous reset in the middle of a disarm streak.
    step(1'b1, LT);
    step(1'b1, LT); chk_a("t6.dis2", 1'b1, 1'b0, 1'b0, 8'd5, 2'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_a("t6.async", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    chk("t6.sticky", 32'(a_sticky), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fresh streak after reset; DEBOUNCE=1 instance reacts to single samples.
    step(1'b1, GT);
    chk_a("t7.gt1", 1'b0, 1'b0, 1'b0, 8'd0, 2'd1);
    chk("t7.c_alarm", 32'(c_alarm), 32'd1);
    chk("t7.c_rise",  32'(c_rise),  32'd1);
    chk("t7.c_state", 32'(c_state), 32'd2);
    step(1'b1, GT);
    chk("t7.c_rise_drop", 32'(c_rise), 32'd0);
    step(1'b1, GT); chk_a("t7.gt3", 1'b1, 1'b1, 1'b0, 8'd1, 2'd2);
    step(1'b1, LT);
    chk_a("t7.lt1", 1'b1, 1'b0, 1'b0, 8'd1, 2'd3);
    chk("t7.c_alarm_fall", 32'(c_alarm), 32'd0);
    chk("t7.c_fall",  32'(c_fall),  32'd1);
    chk("t7.c_state0", 32'(c_state), 32'd0);
    chk("t7.c_cnt",   32'(c_cnt),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
